// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus: command encodings, memory-mapped
// register addresses and the arbiter/sequencer FSM state encoding.
package mem_bus_pkg;

  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin selector.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   req[1:0]   : request vector
//   upd        : commit the current winner as last-granted
//   win[1:0]   : one-hot winner (zero when no request)
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] win
);

  // Id of the port granted last; starts at 1 so port 0 wins the first tie.
  logic last_q, last_d;

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_q ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (upd && (win != 2'b00)) begin
      last_d = win[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory-bus arbiter and sequencer. Grants one request at a time
// (round-robin on ties), drives the shared RAM, owns the LED register and
// returns read data on a single muxed bus with per-port valid strobes.
// Ports:
//   clk, reset              : clock, asynchronous active-low reset
//   reqX/cmdX/addrX/wdataX  : master request, command, address, write data
//   gntX                    : request accepted at this rising edge
//   rvalidX, rdata          : read response strobe per port, shared data
//   ram_addr/ram_write/ram_din/ram_dout : RAM interface (1-cycle read)
//   sw, led                 : switch inputs, LED register
//   busy                    : sequencer not idle
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [1:0]    cmd0,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-2:0] ram_addr,
  output logic          ram_write,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  input  logic [7:0]    sw,
  output logic [7:0]    led,
  output logic          busy
);

  state_e state_q, state_d;

  logic [1:0]    cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          port_q;
  logic [7:0]    led_q;
  logic [DW-1:0] rdata_q;

  logic [1:0]    win;
  logic          take;
  logic          in_ram, in_sw;
  logic          led_we;
  logic [DW-1:0] resp_data;

  // Gate with reset so no grant is reported while reset is held.
  assign take = reset && (state_q == StIdle) && (req0 || req1);

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req   ({req1, req0}),
    .upd   (take),
    .win   (win)
  );

  // Decode on the latched address.
  assign in_ram = ~addr_q[AW-1];
  assign in_sw  = (addr_q == AW'(SW_ADDR));
  assign led_we = (state_q == StAccess) && (cmd_q == MWRITE) && (addr_q == AW'(LED_ADDR));

  // LED space and unmapped space both read as zero.
  always_comb begin
    resp_data = '0;
    if (in_ram) begin
      resp_data = ram_dout;
    end else if (in_sw) begin
      resp_data = {{(DW-8){1'b0}}, sw};
    end
  end

  // State register plus per-transaction latches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= 1'b0;
      led_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        cmd_q   <= win[1] ? cmd1   : cmd0;
        addr_q  <= win[1] ? addr1  : addr0;
        wdata_q <= win[1] ? wdata1 : wdata0;
        port_q  <= win[1];
      end
      if (led_we) begin
        led_q <= wdata_q[7:0];
      end
      if (state_q == StResp) begin
        rdata_q <= resp_data;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (take) state_d = StAccess;
      StAccess: state_d = (cmd_q == MREAD) ? StResp : StIdle;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    gnt0      = take && win[0];
    gnt1      = take && win[1];
    rvalid0   = (state_q == StResp) && !port_q;
    rvalid1   = (state_q == StResp) && port_q;
    rdata     = (state_q == StResp) ? resp_data : rdata_q;
    ram_addr  = addr_q[AW-2:0];
    ram_din   = wdata_q;
    ram_write = (state_q == StAccess) && (cmd_q == MWRITE) && in_ram;
    led       = led_q;
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  cmd0, cmd1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  // Synchronous RAM, registered read, initial content 16'hA000 | index.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    ram_dout = 16'h0;
  end
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_write) mem[ram_addr] <= ram_din;
  end

  mem_arbiter #(.DW(16), .AW(9)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_write(ram_write),
    .ram_din(ram_din), .ram_dout(ram_dout), .sw(sw), .led(led), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0; sw = 8'h00;
    step();
    checks++; if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin errors++;
      $display("FAIL rst_strobes: got %b want 0000", {gnt0, gnt1, rvalid0, rvalid1}); end
    checks++; if ({rdata, ram_din} !== 32'h0) begin errors++;
      $display("FAIL rst_data: got %h want 0", {rdata, ram_din}); end
    checks++; if ({led, ram_addr, ram_write, busy} !== 18'h0) begin errors++;
      $display("FAIL rst_ctrl: got %h want 0", {led, ram_addr, ram_write, busy}); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    req0 = 1; cmd0 = 2'b10; addr0 = 9'h005; wdata0 = 16'hBEEF;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++;
      $display("FAIL wr_gnt: got %b want 10", {gnt0, gnt1}); end
    step(); req0 = 0;
    checks++; if ({ram_write, ram_addr, ram_din, busy} !== {1'b1, 8'h05, 16'hBEEF, 1'b1}) begin
      errors++; $display("FAIL wr_access: got %b %h %h %b want 1 05 beef 1",
                         ram_write, ram_addr, ram_din, busy); end
    step();
    checks++; if ({ram_write, busy} !== 2'b00) begin errors++;
      $display("FAIL wr_done: got %b want 00", {ram_write, busy}); end
    req0 = 1; cmd0 = 2'b01; addr0 = 9'h005;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", gnt0); end
    step(); req0 = 0;
    checks++; if ({ram_write, rvalid0} !== 2'b00) begin errors++;
      $display("FAIL rd_access: got %b want 00", {ram_write, rvalid0}); end
    step();
    checks++; if ({rvalid0, rvalid1, rdata} !== {2'b10, 16'hBEEF}) begin errors++;
      $display("FAIL rd_resp: got %b%b %h want 10 beef", rvalid0, rvalid1, rdata); end
    step();
    checks++; if ({rvalid0, rdata} !== {1'b0, 16'hBEEF}) begin errors++;
      $display("FAIL rd_hold: got %b %h want 0 beef", rvalid0, rdata); end
  endtask

  task automatic test_alternate();
    logic [15:0] exp;
    reset = 1'b0; #1; reset = 1'b1;
    req0 = 1; cmd0 = 2'b01; addr0 = 9'h001;
    req1 = 1; cmd1 = 2'b01; addr1 = 9'h002;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 16'hA001 : 16'hA002;
      checks++; if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL alt_gnt%0d: got %b%b want port %0d", i, gnt0, gnt1, i % 2); end
      step(); step();
      checks++; if ({rvalid0, rvalid1, rdata} !== {(i % 2 == 0), (i % 2 == 1), exp}) begin
        errors++; $display("FAIL alt_resp%0d: got %b%b %h want port %0d %h",
                           i, rvalid0, rvalid1, rdata, i % 2, exp); end
      if (i == 3) begin req0 = 0; req1 = 0; end
      step();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alt_idle: got %b want 0", busy); end
  endtask

  task automatic test_led_sw();
    req1 = 1; cmd1 = 2'b10; addr1 = 9'h100; wdata1 = 16'h12A5;
    #1;
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL led_gnt: got %b want 1", gnt1); end
    step(); req1 = 0;
    checks++; if (ram_write !== 1'b0) begin errors++;
      $display("FAIL led_ramwr: got %b want 0", ram_write); end
    step();
    checks++; if (led !== 8'hA5) begin errors++; $display("FAIL led_val: got %h want a5", led); end
    sw = 8'h3C; req1 = 1; cmd1 = 2'b01; addr1 = 9'h140;
    step(); req1 = 0;
    step();
    checks++; if ({rvalid0, rvalid1, rdata} !== {2'b01, 16'h003C}) begin errors++;
      $display("FAIL sw_read: got %b%b %h want 01 003c", rvalid0, rvalid1, rdata); end
    step();
  endtask

  task automatic test_unmapped();
    req0 = 1; cmd0 = 2'b01; addr0 = 9'h1FF;
    step(); req0 = 0;
    step();
    checks++; if ({rvalid0, rdata} !== {1'b1, 16'h0}) begin errors++;
      $display("FAIL unm_read: got %b %h want 1 0000", rvalid0, rdata); end
    step();
    req0 = 1; cmd0 = 2'b01; addr0 = 9'h100;
    step(); req0 = 0;
    step();
    checks++; if ({rvalid0, rdata} !== {1'b1, 16'h0}) begin errors++;
      $display("FAIL led_read: got %b %h want 1 0000", rvalid0, rdata); end
    step();
    req0 = 1; cmd0 = 2'b10; addr0 = 9'h1FF; wdata0 = 16'hFFFF;
    step(); req0 = 0;
    checks++; if (ram_write !== 1'b0) begin errors++;
      $display("FAIL unm_wr: got %b want 0", ram_write); end
    step();
    checks++; if (led !== 8'hA5) begin errors++; $display("FAIL unm_led: got %h want a5", led); end
    req0 = 1; cmd0 = 2'b01; addr0 = 9'h0FF;
    step(); req0 = 0;
    step();
    checks++; if (rdata !== 16'hA0FF) begin errors++;
      $display("FAIL unm_ram: got %h want a0ff", rdata); end
    step();
    req0 = 1; cmd0 = 2'b11; addr0 = 9'h003;
    step(); req0 = 0;
    checks++; if ({busy, ram_write} !== 2'b10) begin errors++;
      $display("FAIL none_access: got %b want 10", {busy, ram_write}); end
    step();
    checks++; if ({busy, rvalid0, rvalid1} !== 3'b000) begin errors++;
      $display("FAIL none_idle: got %b want 000", {busy, rvalid0, rvalid1}); end
    step();
  endtask

  task automatic test_reset_mid();
    req0 = 1; cmd0 = 2'b01; addr0 = 9'h005;
    step(); req0 = 0;
    step();
    checks++; if (rvalid0 !== 1'b1) begin errors++;
      $display("FAIL rresp_pre: got %b want 1", rvalid0); end
    reset = 1'b0; #1;
    checks++; if ({rvalid0, busy, rdata} !== {2'b00, 16'h0}) begin errors++;
      $display("FAIL rresp_rst: got %b%b %h want 00 0000", rvalid0, busy, rdata); end
    step(); reset = 1'b1;
    req0 = 1; cmd0 = 2'b10; addr0 = 9'h010; wdata0 = 16'h0001;
    step(); req0 = 0;
    checks++; if (ram_write !== 1'b1) begin errors++;
      $display("FAIL racc_pre: got %b want 1", ram_write); end
    reset = 1'b0; #1;
    checks++; if ({ram_write, busy, led, ram_addr, ram_din} !== 34'h0) begin errors++;
      $display("FAIL racc_rst: got %b%b %h %h %h want all 0",
               ram_write, busy, led, ram_addr, ram_din); end
    step(); reset = 1'b1;
    req0 = 1; cmd0 = 2'b01; addr0 = 9'h010;
    step(); req0 = 0;
    step();
    checks++; if ({rvalid0, rdata} !== {1'b1, 16'hA010}) begin errors++;
      $display("FAIL racc_read: got %b %h want 1 a010", rvalid0, rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_led_sw();
    test_unmapped();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory-bus arbiter and sequencer placed between two bus masters (port 0: CPU, port 1: loader/debug master) and the shared 256×16 synchronous RAM plus the memory-mapped LED and switch registers. It grants one request at a time by round-robin and drives the RAM's address, write and data lines. It decodes the 9-bit address into RAM, LED or switch space and returns read data with a per-port valid strobe. It replaces the ad-hoc tri-state `read_data` sharing in the top level with a single owned, muxed bus.

## Interface
Parameters:
- `DW`, 16, data width
- `AW`, 9, bus address width; RAM uses `AW-1` low bits

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req0` / `req1`  in  1  request from port 0 / 1; held until grant
- `cmd0` / `cmd1`  in  2  bus command: `01` = MREAD, `10` = MWRITE, others = NONE
- `addr0` / `addr1`  in  AW  bus address
- `wdata0` / `wdata1`  in  DW  write data
- `gnt0` / `gnt1`  out  1  request accepted at this rising edge
- `rvalid0` / `rvalid1`  out  1  one-cycle read-data-valid strobe
- `rdata`  out  DW  read data, shared by both ports, qualified by `rvalidX`
- `ram_addr`  out  AW-1  RAM read/write address
- `ram_write`  out  1  RAM write enable
- `ram_din`  out  DW  RAM write data
- `ram_dout`  in  DW  RAM registered read data, one cycle latency
- `sw`  in  8  switch inputs
- `led`  out  8  LED register
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE → ACCESS when any `reqX` is high.
  - ACCESS → RESP if the latched cmd is MREAD, otherwise ACCESS → IDLE.
  - RESP → IDLE, unconditionally.
- Arbitration in IDLE:
  - Only one port requesting: that port wins.
  - Both ports requesting: the port not granted last wins.
  - The last-granted pointer resets to 1, so port 0 wins the first tie.
- `gntX` is combinational and high only in IDLE for the winner. At that edge the arbiter latches the winner's cmd, addr, wdata and port id.
- Address decode on the latched address:
  - RAM: `addr[8]==0`.
  - LED: `addr==9'h100`.
  - SW: `addr==9'h140`.
  - Anything else is unmapped.
- ACCESS:
  - `ram_addr` = latched `addr[7:0]`.
  - `ram_din` = latched wdata.
  - `ram_write` = MWRITE and RAM space.
  - MWRITE to LED updates `led` with `wdata[7:0]` at the end of ACCESS.
- RESP: `rvalidX` is high for the latched port only. `rdata` by space:
  - RAM: `ram_dout`.
  - SW: `{8'b0, sw}`, sampled this cycle.
  - Unmapped: 0.
- Other read/write cases:
  - MWRITE to SW or unmapped space: no effect.
  - MREAD to LED space: returns 0.
  - cmd NONE: consumed; no RAM write, no rvalid.
- Outside RESP, `rdata` holds its last value and both `rvalid` are 0.

## Timing
- Reset values: state IDLE, `gnt*` 0, `rvalid*` 0, `rdata` 0, `led` 0, `ram_write` 0, `ram_addr` 0, `ram_din` 0, `busy` 0, pointer = 1.
- Read: grant in cycle N; ACCESS in N+1; `rvalid` and `rdata` in N+2; next grant possible in N+3.
- Write: grant in cycle N; ACCESS in N+1, with the RAM/LED write at the N+1 edge; next grant possible in N+2.
- A requester keeping `req` high after its grant is treated as a new request in the next IDLE.
- Reset asserted in ACCESS before the clock edge: no RAM or LED write occurs. Reset in RESP: `rvalid` drops immediately.
- `ram_write` is never high outside ACCESS.

## Structure
- Shared package `mem_bus_pkg`:
  - `MREAD` and `MWRITE` command constants.
  - `LED_ADDR` = 9'h100 and `SW_ADDR` = 9'h140.
  - FSM state encoding IDLE, ACCESS, RESP.
- Sub-module `rr_arb2`: 2-input round-robin selector holding the last-granted pointer. Inputs: `req[1:0]` and an update strobe. Output: one-hot `win[1:0]`.
- The FSM, address decode, LED register and response mux live in `mem_arbiter`.

## Test plan
- Reset, then port 0 MWRITE addr 9'h005 data 16'hBEEF, then MREAD 9'h005 → `ram_write` high one cycle with `ram_addr`=05; `rvalid0` two cycles after the read grant with `rdata`=BEEF.
- `req0` and `req1` both held high with reads to 9'h001 and 9'h002 → grants alternate 0,1,0,1; the first grant goes to port 0; each `rvalid` appears on the matching port only.
- Port 1 MWRITE 9'h100 data 16'h12A5 → `led`=A5 after ACCESS; no `ram_write`. With `sw`=8'h3C, MREAD 9'h140 → `rdata`=16'h003C.
- MREAD 9'h1FF → `rdata`=0 with `rvalid`. MWRITE 9'h1FF → `led` and RAM unchanged. cmd `11` → no `rvalid`, FSM returns to IDLE after one ACCESS cycle.
- Reset pulse during ACCESS of MWRITE 9'h010 data 16'h0001 → a later read of 9'h010 returns the initial RAM content; all outputs return to their reset values asynchronously.
